// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag width, opcode encodings, "no value" bus constants
// and the operand-resolution helper used by the issue stage.
package tomasulo_pkg;

   localparam int TAG_W = 3;
   localparam int REG_N = 8;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_RR_A  = 3'd1,
      OP_RR_B  = 3'd2,
      OP_IMM_A = 3'd3,
      OP_IMM_B = 3'd4,
      OP_READ  = 3'd5,
      OP_RR_C  = 3'd6,
      OP_RR_D  = 3'd7
   } opcode_e;

   localparam logic [15:0]      VJ_VK_SEM_VALOR = 16'hFFF0;
   localparam logic [TAG_W-1:0] QJ_QK_SEM_VALOR = 3'b000;
   localparam logic [6:0]       A_SEM_VALOR     = 7'b1111000;

   typedef struct packed {
      logic [15:0]      v;
      logic [TAG_W-1:0] q;
   } src_t;

   function automatic logic is_imm(input logic [2:0] op);
      return (op == OP_IMM_A) || (op == OP_IMM_B);
   endfunction

   function automatic logic writes_dest(input logic [2:0] op);
      return (op != OP_NOP) && (op != OP_READ);
   endfunction

   // A ready register wins, then a same-cycle CDB hit, otherwise wait on the producer tag.
   function automatic src_t resolve_src(input logic [TAG_W-1:0] qi, input logic [15:0] reg_val,
                                        input logic cdb_hit, input logic [15:0] cdb_value);
      src_t r;
      if (qi == QJ_QK_SEM_VALOR) begin
         r.v = reg_val;
         r.q = QJ_QK_SEM_VALOR;
      end else if (cdb_hit) begin
         r.v = cdb_value;
         r.q = QJ_QK_SEM_VALOR;
      end else begin
         r.v = VJ_VK_SEM_VALOR;
         r.q = qi;
      end
      return r;
   endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Instruction-queue handshake plus reservation-station load bus; master is the issue unit,
// slave is the queue/station side.
interface issue_unit_if #(
   parameter int N_RS = 4
);
   import tomasulo_pkg::*;

   logic             Instr_valid;
   logic             Instr_ready;
   logic [15:0]      Instr;
   logic [N_RS-1:0]  Busy;
   logic [N_RS-1:0]  Enable_VQ;
   logic [2:0]       Opcode;
   logic [2:0]       R_target;
   logic [15:0]      Vj;
   logic [15:0]      Vk;
   logic [TAG_W-1:0] Qj;
   logic [TAG_W-1:0] Qk;
   logic [6:0]       A;

   modport master (
      input  Instr_valid, Instr, Busy,
      output Instr_ready, Enable_VQ, Opcode, R_target, Vj, Vk, Qj, Qk, A
   );

   modport slave (
      output Instr_valid, Instr, Busy,
      input  Instr_ready, Enable_VQ, Opcode, R_target, Vj, Vk, Qj, Qk, A
   );
endinterface

// File: rtl/issue_unit_reg_status_table.sv
// Register status table: per-register producer tag (Qi), two combinational read ports,
// one rename write port and CDB clear; a rename beats a clear of the same register.
module reg_status_table
   import tomasulo_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       rd_a_addr_i,
   input  logic [2:0]       rd_b_addr_i,
   output logic [TAG_W-1:0] rd_a_tag_o,
   output logic [TAG_W-1:0] rd_b_tag_o,
   input  logic             ren_en_i,
   input  logic [2:0]       ren_addr_i,
   input  logic [TAG_W-1:0] ren_tag_i,
   input  logic             cdb_valid_i,
   input  logic [TAG_W-1:0] cdb_tag_i
);
   logic [REG_N-1:0][TAG_W-1:0] qi_w;

   for (genvar gi = 0; gi < REG_N; gi++) begin : g_qi
      logic [TAG_W-1:0] qi_q;
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            qi_q <= QJ_QK_SEM_VALOR;
         end else if (ren_en_i && (ren_addr_i == 3'(gi))) begin
            qi_q <= ren_tag_i;
         end else if (cdb_valid_i && (qi_q == cdb_tag_i)) begin
            qi_q <= QJ_QK_SEM_VALOR;
         end
      end
      assign qi_w[gi] = qi_q;
   end

   assign rd_a_tag_o = qi_w[rd_a_addr_i];
   assign rd_b_tag_o = qi_w[rd_b_addr_i];
endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: allocates the lowest free station, resolves operands, renames Rx.
// ISSUE_CDB_BYPASS_EN: operands take a same-cycle CDB value instead of stalling one cycle.
module issue_unit
   import tomasulo_pkg::*;
#(
   parameter int N_RS = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [127:0]     Reg_data,
   input  logic             Cdb_valid,
   input  logic [TAG_W-1:0] Cdb_tag,
   input  logic [15:0]      Cdb_value,
   issue_unit_if.master     rs_if
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_e;

   state_e           state_q;
   logic [N_RS-1:0]  en_q;
   logic [2:0]       op_q, rt_q;
   logic [15:0]      vj_q, vk_q;
   logic [TAG_W-1:0] qj_q, qk_q;
   logic [6:0]       a_q;

   logic [2:0]       f_op, f_rx, f_ry, f_rz;
   logic [6:0]       f_imm;
   logic [TAG_W-1:0] qi_j, qi_k, sel_idx, ren_tag;
   logic [N_RS-1:0]  avail;
   logic             any_avail, stall, xfer, issue_fire, ren_en;
   logic             match_j, match_k, hit_j, hit_k;
   src_t             src_j, src_k;
   logic [15:0]      vk_d;
   logic [TAG_W-1:0] qk_d;
   logic [6:0]       a_d;

   assign {f_op, f_rx, f_ry, f_rz} = rs_if.Instr[15:4];
   assign f_imm = rs_if.Instr[6:0];

   assign match_j = Cdb_valid && (qi_j != QJ_QK_SEM_VALOR) && (Cdb_tag == qi_j);
   assign match_k = Cdb_valid && (qi_k != QJ_QK_SEM_VALOR) && (Cdb_tag == qi_k);
`ifdef ISSUE_CDB_BYPASS_EN
   assign hit_j = match_j;
   assign hit_k = match_k;
   assign stall = 1'b0;
`else
   assign hit_j = 1'b0;
   assign hit_k = 1'b0;
   assign stall = match_j || match_k;
`endif

   // Qi is read before this edge's rename, so Ry == Rx sees the older producer.
   assign src_j = resolve_src(qi_j, Reg_data[{f_ry, 4'b0000} +: 16], hit_j, Cdb_value);
   assign src_k = resolve_src(qi_k, Reg_data[{f_rz, 4'b0000} +: 16], hit_k, Cdb_value);

   always_comb begin
      vk_d = src_k.v;
      qk_d = src_k.q;
      a_d  = A_SEM_VALOR;
      if (is_imm(f_op)) begin
         vk_d = VJ_VK_SEM_VALOR;
         qk_d = QJ_QK_SEM_VALOR;
         a_d  = f_imm;
      end
   end

   always_comb begin
      sel_idx   = '0;
      any_avail = 1'b0;
      for (int k = N_RS - 1; k >= 0; k--) begin
         if (avail[k]) begin
            sel_idx   = TAG_W'(k);
            any_avail = 1'b1;
         end
      end
   end

   assign rs_if.Instr_ready = !Reset && (state_q == S_IDLE) && any_avail && !stall;
   assign xfer       = rs_if.Instr_valid && rs_if.Instr_ready;
   assign issue_fire = xfer && (f_op != OP_NOP);
   assign ren_en     = issue_fire && writes_dest(f_op);
   assign ren_tag    = sel_idx + TAG_W'(1);

   // A just-issued station stays masked until its Busy is seen or two edges pass.
   for (genvar gi = 0; gi < N_RS; gi++) begin : g_rsv
      logic [1:0] cnt_q;
      always_ff @(posedge Clock) begin
         if (Reset) begin
            cnt_q <= 2'd0;
         end else if (issue_fire && (sel_idx == TAG_W'(gi))) begin
            cnt_q <= 2'd2;
         end else if (rs_if.Busy[gi]) begin
            cnt_q <= 2'd0;
         end else if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
         end
      end
      assign avail[gi] = !rs_if.Busy[gi] && (cnt_q == 2'd0);
   end

   reg_status_table u_rst (
      .clk_i       (Clock),
      .rst_i       (Reset),
      .rd_a_addr_i (f_ry),
      .rd_b_addr_i (f_rz),
      .rd_a_tag_o  (qi_j),
      .rd_b_tag_o  (qi_k),
      .ren_en_i    (ren_en),
      .ren_addr_i  (f_rx),
      .ren_tag_i   (ren_tag),
      .cdb_valid_i (Cdb_valid),
      .cdb_tag_i   (Cdb_tag)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         en_q    <= '0;
         op_q    <= 3'd0;
         rt_q    <= 3'd0;
         vj_q    <= VJ_VK_SEM_VALOR;
         vk_q    <= VJ_VK_SEM_VALOR;
         qj_q    <= QJ_QK_SEM_VALOR;
         qk_q    <= QJ_QK_SEM_VALOR;
         a_q     <= A_SEM_VALOR;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (issue_fire) begin
                  state_q <= S_ISSUE;
                  en_q    <= N_RS'(1) << sel_idx;
                  op_q    <= f_op;
                  rt_q    <= f_rx;
                  vj_q    <= src_j.v;
                  qj_q    <= src_j.q;
                  vk_q    <= vk_d;
                  qk_q    <= qk_d;
                  a_q     <= a_d;
               end
            end
            S_ISSUE: begin
               state_q <= S_SETTLE;
               en_q    <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rs_if.Enable_VQ = en_q;
   assign rs_if.Opcode    = op_q;
   assign rs_if.R_target  = rt_q;
   assign rs_if.Vj        = vj_q;
   assign rs_if.Vk        = vk_q;
   assign rs_if.Qj        = qj_q;
   assign rs_if.Qk        = qk_q;
   assign rs_if.A         = a_q;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: expected station writes are queued at drive time and
// popped by a monitor whenever Enable_VQ strobes.
module tb_issue_unit;
   typedef struct packed {
      logic [3:0]  en;
      logic [2:0]  op;
      logic [2:0]  rt;
      logic [15:0] vj;
      logic [15:0] vk;
      logic [2:0]  qj;
      logic [2:0]  qk;
      logic [6:0]  a;
   } iss_t;

   localparam logic [6:0]  A_NONE = 7'b1111000;
   localparam logic [15:0] V_NONE = 16'hFFF0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] reg_data;
   logic         cdb_valid;
   logic [2:0]   cdb_tag;
   logic [15:0]  cdb_value;

   issue_unit_if #(.N_RS(4)) rs_if ();

   issue_unit #(.N_RS(4)) dut (
      .Clock     (clk),
      .Reset     (rst),
      .Reg_data  (reg_data),
      .Cdb_valid (cdb_valid),
      .Cdb_tag   (cdb_tag),
      .Cdb_value (cdb_value),
      .rs_if     (rs_if)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   iss_t exp_q[$];
   iss_t obs, last, want, hold;
   logic hold_chk = 1'b0;

   assign obs = {rs_if.Enable_VQ, rs_if.Opcode, rs_if.R_target, rs_if.Vj, rs_if.Vk,
                 rs_if.Qj, rs_if.Qk, rs_if.A};

   function automatic iss_t mk(input logic [3:0] en, input logic [2:0] op, input logic [2:0] rt,
                               input logic [15:0] vj, input logic [15:0] vk,
                               input logic [2:0] qj, input logic [2:0] qk, input logic [6:0] a);
      return {en, op, rt, vj, vk, qj, qk, a};
   endfunction

   function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rx,
                                      input logic [2:0] ry, input logic [2:0] rz);
      return {op, rx, ry, rz, 4'b0000};
   endfunction

   function automatic logic [15:0] im(input logic [2:0] op, input logic [2:0] rx,
                                      input logic [2:0] ry, input logic [6:0] imm);
      return {op, rx, ry, imm};
   endfunction

   // Monitor: every strobe is matched against the scoreboard; the following cycle must hold the bus.
   always @(negedge clk) begin
      if (hold_chk && !rst) begin
         hold = last;
         hold.en = 4'b0000;
         n_vec++;
         assert (obs === hold) else begin
            n_err++;
            $error("FAIL bus_hold observed=%h required=%h", obs, hold);
         end
      end
      hold_chk = 1'b0;
      if (rs_if.Enable_VQ !== 4'b0000) begin
         n_vec++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_strobe observed=%h required=no strobe", obs);
         end
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_vec++;
            assert (obs === want) else begin
               n_err++;
               $error("FAIL issue_bus observed=%h required=%h", obs, want);
            end
            $display("issue en=%b op=%0d rt=%0d vj=%h vk=%h qj=%0d qk=%0d a=%h",
                     obs.en, obs.op, obs.rt, obs.vj, obs.vk, obs.qj, obs.qk, obs.a);
            last = obs;
            hold_chk = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] req);
      n_vec++;
      assert (got === req) else begin
         n_err++;
         $error("FAIL %s observed=%h required=%h", tag, got, req);
      end
   endtask

   task automatic drive(input logic [15:0] ins, input iss_t e);
      rs_if.Instr       = ins;
      rs_if.Instr_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for a transfer; with post set, also checks Instr_ready drops for ISSUE and SETTLE.
   task automatic xfer(input string tag, input int budget, input bit post);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = rs_if.Instr_ready;
      end
      n_vec++;
      assert (done) else begin
         n_err++;
         $error("FAIL %s_accept observed=no transfer required=transfer within %0d cycles", tag, budget);
      end
      if (!done) void'(exp_q.pop_back());
      if (done) begin
         @(posedge clk);
         #1;
      end
      rs_if.Instr_valid = 1'b0;
      cdb_valid = 1'b0;
      if (done && post) begin
         @(negedge clk);
         chk({tag, "_ready_in_issue"}, 64'(rs_if.Instr_ready), 64'd0);
         @(negedge clk);
         chk({tag, "_ready_in_settle"}, 64'(rs_if.Instr_ready), 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reg_data  = {16'd70, 16'd60, 16'd50, 16'd40, 16'd7, 16'd5, 16'd100, 16'h0011};
      cdb_valid = 1'b0;
      cdb_tag   = 3'd0;
      cdb_value = 16'd0;
      rs_if.Busy        = 4'b0000;
      rs_if.Instr       = rr(3'd1, 3'd1, 3'd2, 3'd3);
      rs_if.Instr_valid = 1'b1;

      // Reset values, with a valid instruction waiting.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 64'(rs_if.Instr_ready), 64'd0);
      chk("reset_bus", 64'(obs), 64'(mk(4'b0000, 3'd0, 3'd0, V_NONE, V_NONE, 3'd0, 3'd0, A_NONE)));
      @(posedge clk);
      #1;
      rst = 1'b0;
      rs_if.Instr_valid = 1'b0;

      // ADD R1,R2,R3 to station 0; Qi[1] becomes 1.
      drive(rr(3'd1, 3'd1, 3'd2, 3'd3), mk(4'b0001, 3'd1, 3'd1, 16'd5, 16'd7, 3'd0, 3'd0, A_NONE));
      xfer("add", 4, 1'b1);

      // NOP is consumed without a strobe and leaves the FSM ready.
      rs_if.Busy = 4'b0001;
      rs_if.Instr = rr(3'd0, 3'd2, 3'd0, 3'd0);
      rs_if.Instr_valid = 1'b1;
      @(negedge clk);
      chk("nop_ready", 64'(rs_if.Instr_ready), 64'd1);
      @(posedge clk);
      #1;
      rs_if.Instr_valid = 1'b0;
      @(negedge clk);
      chk("nop_ready_after", 64'(rs_if.Instr_ready), 64'd1);
      @(posedge clk);
      #1;

      // SUB R4,R1,R2 depends on station 0 (tag 1); goes to station 1, Qi[4] becomes 2.
      drive(rr(3'd2, 3'd4, 3'd1, 3'd2), mk(4'b0010, 3'd2, 3'd4, V_NONE, 16'd5, 3'd1, 3'd0, A_NONE));
      xfer("sub", 4, 1'b1);

      // All busy: no acceptance until station 2 frees.
      rs_if.Busy = 4'b1111;
      drive(rr(3'd1, 3'd5, 3'd6, 3'd7), mk(4'b0100, 3'd1, 3'd5, 16'd60, 16'd70, 3'd0, 3'd0, A_NONE));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("all_busy_ready", 64'(rs_if.Instr_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      rs_if.Busy = 4'b1011;
      xfer("busy_release", 4, 1'b1);

      // CDB tag 1 = 42 broadcast alongside SUB R6,R1,R2 (Qi[1] is still 1).
      rs_if.Busy = 4'b0111;
      cdb_valid = 1'b1;
      cdb_tag   = 3'd1;
      cdb_value = 16'd42;
`ifdef ISSUE_CDB_BYPASS_EN
      drive(rr(3'd2, 3'd6, 3'd1, 3'd2), mk(4'b1000, 3'd2, 3'd6, 16'd42, 16'd5, 3'd0, 3'd0, A_NONE));
      xfer("cdb_bypass", 1, 1'b1);
`else
      drive(rr(3'd2, 3'd6, 3'd1, 3'd2), mk(4'b1000, 3'd2, 3'd6, 16'd100, 16'd5, 3'd0, 3'd0, A_NONE));
      @(negedge clk);
      chk("cdb_stall_ready", 64'(rs_if.Instr_ready), 64'd0);
      @(posedge clk);
      #1;
      cdb_valid = 1'b0;
      xfer("cdb_after_stall", 1, 1'b1);
`endif

      // Opcode 5 reads R4 (tag 2) and R3, renames nothing; then ADDI R3,R0,0x15.
      rs_if.Busy = 4'b1110;
      drive(rr(3'd5, 3'd0, 3'd4, 3'd3), mk(4'b0001, 3'd5, 3'd0, V_NONE, 16'd7, 3'd2, 3'd0, A_NONE));
      xfer("op5", 4, 1'b1);
      rs_if.Busy = 4'b1101;
      drive(im(3'd3, 3'd3, 3'd0, 7'h15), mk(4'b0010, 3'd3, 3'd3, 16'h0011, V_NONE, 3'd0, 3'd0, 7'h15));
      xfer("imm", 4, 1'b1);

      // Reset raised during ISSUE: bus returns to reset values and no further strobe.
      rs_if.Busy = 4'b0000;
      drive(rr(3'd1, 3'd7, 3'd1, 3'd1), mk(4'b0001, 3'd1, 3'd7, 16'd100, 16'd100, 3'd0, 3'd0, A_NONE));
      xfer("pre_reset", 4, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_in_issue_bus", 64'(obs), 64'(mk(4'b0000, 3'd0, 3'd0, V_NONE, V_NONE, 3'd0, 3'd0, A_NONE)));
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_strobe_after_reset", 64'(rs_if.Enable_VQ), 64'd0);
      end
      @(posedge clk);
      #1;

      // Qi for R4 and R6 were cleared by reset, so both sources come from the register file.
      drive(rr(3'd1, 3'd1, 3'd4, 3'd6), mk(4'b0001, 3'd1, 3'd1, 16'd40, 16'd60, 3'd0, 3'd0, A_NONE));
      xfer("post_reset", 4, 1'b1);

      repeat (2) @(negedge clk);
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
